// File: rtl/mcycle_ctrl_pkg.sv
// Shared types for the multicycle controller: state encoding, mux select codes,
// op codes and the Moore control-word decode used by the FSM.
package mcycle_ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_EXECUTEM = 4'd10,
    S_MULWB    = 4'd11,
    S_FPUEXEC  = 4'd12,
    S_FPUWB    = 4'd13,
    S_UNKNOWN  = 4'd14
  } state_t;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_MULRESULT = 2'b11;

  localparam logic [1:0] SRCA_REG  = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b01;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_FPU = 2'b11;

  typedef struct packed {
    logic       ir_write;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       fpu_w;
    logic       branch;
    logic       adr_src;
    logic       alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
  } ctrl_t;

  // Moore datapath control word for a given state (before memory gating).
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c            = '0;
    c.result_src = RES_ALUOUT;
    c.alu_src_a  = SRCA_REG;
    c.alu_src_b  = SRCB_REG;
    case (s)
      S_FETCH: begin
        c.ir_write = 1'b1; c.next_pc = 1'b1;
        c.result_src = RES_ALURESULT; c.alu_src_a = SRCA_PC; c.alu_src_b = SRCB_FOUR;
      end
      S_DECODE: begin
        c.result_src = RES_ALURESULT; c.alu_src_a = SRCA_PC; c.alu_src_b = SRCB_FOUR;
      end
      S_EXECUTER: c.alu_op = 1'b1;
      S_EXECUTEI: begin c.alu_op = 1'b1; c.alu_src_b = SRCB_IMM; end
      S_ALUWB:    c.reg_w = 1'b1;
      S_MEMADR:   c.alu_src_b = SRCB_IMM;
      S_MEMRD:    c.adr_src = 1'b1;
      S_MEMWR:    begin c.adr_src = 1'b1; c.mem_w = 1'b1; end
      S_MEMWB:    begin c.reg_w = 1'b1; c.result_src = RES_DATA; end
      S_BRANCH: begin
        c.branch = 1'b1; c.result_src = RES_ALURESULT; c.alu_src_b = SRCB_IMM;
      end
      S_MULWB:    begin c.reg_w = 1'b1; c.result_src = RES_MULRESULT; end
      S_FPUWB:    c.fpu_w = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mcycle_ctrl_fsm_if.sv
// Decoder/memory/FPU inputs and datapath control outputs of the multicycle controller.
interface mcycle_ctrl_fsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       mul_instr;
  logic       mem_ready;
  logic       fpu_done;

  logic       IRWrite, NextPC, RegW, MemW, FPUW, Branch, AdrSrc, ALUOp;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic       MulStart, FpuStart, fault;
  logic [3:0] state_o;

  modport master (
    output Op, Funct, mul_instr, mem_ready, fpu_done,
    input  IRWrite, NextPC, RegW, MemW, FPUW, Branch, AdrSrc, ALUOp,
    input  ALUSrcA, ALUSrcB, ResultSrc, MulStart, FpuStart, fault, state_o
  );

  modport slave (
    input  Op, Funct, mul_instr, mem_ready, fpu_done,
    output IRWrite, NextPC, RegW, MemW, FPUW, Branch, AdrSrc, ALUOp,
    output ALUSrcA, ALUSrcB, ResultSrc, MulStart, FpuStart, fault, state_o
  );
endinterface

// File: rtl/mc_wait_cnt.sv
// Loadable up/down wait counter with zero and terminal-count flags; shared by
// the multiply countdown and the FPU timeout.
module mc_wait_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] term_val,
  output logic         zero_c,
  output logic         term_c
);

  logic [W-1:0] count_q;

  // Load wins over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en) begin
      count_q <= up ? count_q + W'(1) : count_q - W'(1);
    end
  end

  assign zero_c = (count_q == '0);
  assign term_c = (count_q == term_val);

endmodule

// File: rtl/mcycle_ctrl_fsm.sv
// Multicycle main control FSM with multi-cycle multiply, variable-latency FPU
// with timeout, and optional memory wait-state handshaking.
module mcycle_ctrl_fsm
  import mcycle_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT       = 3,
  parameter int unsigned FPU_EN        = 1,
  parameter int unsigned MEM_HANDSHAKE = 1,
  parameter int unsigned FPU_TIMEOUT   = 63
) (
  input logic              clk,
  input logic              reset_n,
  mcycle_ctrl_fsm_if.slave bus
);

  localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] FPU_TERM = CNT_W'(FPU_TIMEOUT - 1);

  state_t state_q, state_d;
  ctrl_t  ctrl_q;
  logic   mul_start_q, fpu_start_q, fault_q;
  logic   mem_ok_c, timeout_c, mul_entry_c, fpu_entry_c;
  logic   cnt_load, cnt_en, cnt_up, cnt_zero_c, cnt_term_c;
  logic [CNT_W-1:0] cnt_init;
  logic   unused_funct;

  assign unused_funct = ^bus.Funct[4:1];
  assign mem_ok_c     = (MEM_HANDSHAKE == 0) || bus.mem_ready;

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    timeout_c = 1'b0;
    unique case (state_q)
      S_FETCH:  if (mem_ok_c) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          OP_DP: begin
            if (bus.mul_instr)     state_d = S_EXECUTEM;
            else if (bus.Funct[5]) state_d = S_EXECUTEI;
            else                   state_d = S_EXECUTER;
          end
          OP_MEM:  state_d = S_MEMADR;
          OP_BR:   state_d = S_BRANCH;
          OP_FPU:  state_d = (FPU_EN != 0) ? S_FPUEXEC : S_UNKNOWN;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR:   state_d = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    if (mem_ok_c) state_d = S_MEMWB;
      S_MEMWR:    if (mem_ok_c) state_d = S_FETCH;
      S_EXECUTER,
      S_EXECUTEI: state_d = S_ALUWB;
      S_EXECUTEM: if (cnt_zero_c) state_d = S_MULWB;
      S_FPUEXEC: begin
        if (bus.fpu_done) begin
          state_d = S_FPUWB;
        end else if (cnt_term_c) begin
          state_d   = S_FETCH;
          timeout_c = 1'b1;
        end
      end
      default:    state_d = S_FETCH;
    endcase
  end

  // Counter is loaded on the entry transition so the first cycle in the state sees the initial value.
  always_comb begin
    mul_entry_c = (state_d == S_EXECUTEM) && (state_q != S_EXECUTEM);
    fpu_entry_c = (state_d == S_FPUEXEC) && (state_q != S_FPUEXEC);
    cnt_load    = mul_entry_c || fpu_entry_c;
    cnt_init    = mul_entry_c ? MUL_INIT : '0;
    cnt_up      = (state_q == S_FPUEXEC);
    cnt_en      = (state_q == S_EXECUTEM) || ((state_q == S_FPUEXEC) && !bus.fpu_done);
  end

  mc_wait_cnt #(.W(CNT_W)) u_wait_cnt (
    .clk      (clk),
    .rst_n    (reset_n),
    .load     (cnt_load),
    .en       (cnt_en),
    .up       (cnt_up),
    .load_val (cnt_init),
    .term_val (FPU_TERM),
    .zero_c   (cnt_zero_c),
    .term_c   (cnt_term_c)
  );

  // State and output registers; outputs are decoded from the next state so they align with state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_FETCH;
      ctrl_q      <= decode_ctrl(S_FETCH);
      mul_start_q <= 1'b0;
      fpu_start_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= decode_ctrl(state_d);
      mul_start_q <= mul_entry_c;
      fpu_start_q <= fpu_entry_c;
      fault_q     <= (state_d == S_UNKNOWN) || timeout_c;
    end
  end

  // PC/IR updates are qualified by the memory completing the fetch.
  assign bus.IRWrite   = ctrl_q.ir_write & mem_ok_c;
  assign bus.NextPC    = ctrl_q.next_pc & mem_ok_c;
  assign bus.RegW      = ctrl_q.reg_w;
  assign bus.MemW      = ctrl_q.mem_w;
  assign bus.FPUW      = ctrl_q.fpu_w;
  assign bus.Branch    = ctrl_q.branch;
  assign bus.AdrSrc    = ctrl_q.adr_src;
  assign bus.ALUOp     = ctrl_q.alu_op;
  assign bus.ALUSrcA   = ctrl_q.alu_src_a;
  assign bus.ALUSrcB   = ctrl_q.alu_src_b;
  assign bus.ResultSrc = ctrl_q.result_src;
  assign bus.MulStart  = mul_start_q;
  assign bus.FpuStart  = fpu_start_q;
  assign bus.fault     = fault_q;
  assign bus.state_o   = state_q;

endmodule
